// File: rtl/epmp_defs.sv
// epmp_defs: shared ALU command codes, opcodes and sequencer states for the EPMP core
package epmp_defs;
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;
  localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_CLR = 4'h2, ALU_NEG = 4'h3,
                         ALU_INR = 4'h4, ALU_DCR = 4'h5, ALU_AND = 4'h6, ALU_OR = 4'h7,
                         ALU_LOAD = 4'h8;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_CLR = 4'h2, OP_NEG = 4'h3,
                         OP_INR = 4'h4, OP_DCR = 4'h5, OP_AND = 4'h6, OP_OR = 4'h7,
                         OP_LDA = 4'h8, OP_LDI = 4'h9, OP_STA = 4'hA, OP_JMP = 4'hB,
                         OP_JC = 4'hC, OP_JNC = 4'hD, OP_NOP = 4'hE, OP_HLT = 4'hF;
endpackage

// File: rtl/epmp_decode.sv
// epmp_decode: maps sequencer state and opcode to bus strobes and the ALU command
module epmp_decode
  import epmp_defs::*;
(
  input  state_t     state,
  input  logic       Reset,
  input  logic [3:0] op,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       alu_en,
  output logic       acc_out_en,
  output logic       imm_out_en,
  output logic       halted,
  output logic [3:0] alu_cmd
);
  logic d_rd, d_alu, d_imm, d_acc, exec;
  always_comb begin
    d_rd = 1'b0;
    d_alu = 1'b0;
    d_imm = 1'b0;
    d_acc = 1'b0;
    alu_cmd = ALU_ADD;
    case (op)
      OP_ADD: begin d_rd = 1'b1; d_alu = 1'b1; alu_cmd = ALU_ADD; end
      OP_SUB: begin d_rd = 1'b1; d_alu = 1'b1; alu_cmd = ALU_SUB; end
      OP_AND: begin d_rd = 1'b1; d_alu = 1'b1; alu_cmd = ALU_AND; end
      OP_OR:  begin d_rd = 1'b1; d_alu = 1'b1; alu_cmd = ALU_OR; end
      OP_LDA: begin d_rd = 1'b1; d_alu = 1'b1; alu_cmd = ALU_LOAD; end
      OP_CLR: begin d_alu = 1'b1; alu_cmd = ALU_CLR; end
      OP_NEG: begin d_alu = 1'b1; alu_cmd = ALU_NEG; end
      OP_INR: begin d_alu = 1'b1; alu_cmd = ALU_INR; end
      OP_DCR: begin d_alu = 1'b1; alu_cmd = ALU_DCR; end
      OP_LDI: begin d_imm = 1'b1; d_alu = 1'b1; alu_cmd = ALU_LOAD; end
      OP_STA: d_acc = 1'b1;
      OP_JMP, OP_JC, OP_JNC, OP_NOP, OP_HLT: ;
    endcase
  end
  // Reset masks strobes combinationally since the registered state may still read EXEC
  assign exec = state == EXEC && !Reset;
  assign mem_rd = exec && d_rd;
  assign alu_en = exec && d_alu;
  assign imm_out_en = exec && d_imm;
  assign acc_out_en = exec && d_acc;
  assign mem_wr = exec && d_acc;
  assign halted = state == HALT && !Reset;
endmodule

// File: rtl/epmp_ctrl.sv
// epmp_ctrl: fetch/decode/execute sequencer owning PC, IR and the shared ACC bus
module epmp_ctrl
  import epmp_defs::*;
#(
  parameter int PC_W = 8,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic [11:0]     Instr,
  input  logic            C,
  inout  wire  [7:0]      ACC_bus,
  output logic [PC_W-1:0] Prog_Addr,
  output logic [7:0]      Mem_Addr,
  output logic            Mem_Rd,
  output logic            Mem_Wr,
  output logic [3:0]      ALU_Cmd,
  output logic            ALU_En,
  output logic            ACC_Out_En,
  output logic            Imm_Out_En,
  output logic            Halted,
  output logic [11:0]     Debug_IR
);
  state_t state;
  logic [PC_W-1:0] pc;
  logic [11:0] ir;
  logic [3:0] op;
  logic take;
  assign op = ir[11:8];
  assign take = op == OP_JMP || (op == OP_JC && C) || (op == OP_JNC && !C);
  always_ff @(posedge clk)
    if (Reset) begin
      state <= FETCH;
      pc <= PC_W'(RESET_PC);
      ir <= '0;
    end else
      case (state)
        FETCH: begin
          ir <= Instr;
          pc <= pc + PC_W'(1);
          state <= DECODE;
        end
        DECODE: state <= EXEC;
        EXEC: begin
          state <= op == OP_HLT ? HALT : FETCH;
          if (take) pc <= ir[PC_W-1:0];
        end
        HALT: state <= HALT;
      endcase
  epmp_decode u_decode (
    .state(state), .Reset(Reset), .op(op), .mem_rd(Mem_Rd), .mem_wr(Mem_Wr),
    .alu_en(ALU_En), .acc_out_en(ACC_Out_En), .imm_out_en(Imm_Out_En),
    .halted(Halted), .alu_cmd(ALU_Cmd)
  );
  assign ACC_bus = Imm_Out_En ? ir[7:0] : 8'bz;
  assign Prog_Addr = pc;
  assign Mem_Addr = ir[7:0];
  assign Debug_IR = ir;
endmodule

// File: tb/tb_epmp_ctrl.sv
// tb_epmp_ctrl: directed programs with a per-cycle scoreboard and spot checks
module tb_epmp_ctrl;
  logic clk = 1'b0, Reset = 1'b1, C = 1'b0;
  logic [11:0] prog [256];
  logic [11:0] Instr, Debug_IR;
  logic [7:0] Prog_Addr, Mem_Addr;
  logic [3:0] ALU_Cmd;
  logic Mem_Rd, Mem_Wr, ALU_En, ACC_Out_En, Imm_Out_En, Halted;
  wire [7:0] ACC_bus;
  typedef struct {string tag; logic [45:0] v; logic [45:0] m;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0;
  logic [1:0] m_st;
  logic [7:0] m_pc;
  logic [11:0] m_ir;
  wire [45:0] obs = {Halted, Mem_Rd, Mem_Wr, ALU_En, ACC_Out_En, Imm_Out_En, ALU_Cmd,
                     Mem_Addr, ACC_bus, Prog_Addr, Debug_IR};
  assign Instr = prog[Prog_Addr];
  always #5 clk = ~clk;
  epmp_ctrl #(.PC_W(8), .RESET_PC(0)) dut (
    .clk(clk), .Reset(Reset), .Instr(Instr), .C(C), .ACC_bus(ACC_bus),
    .Prog_Addr(Prog_Addr), .Mem_Addr(Mem_Addr), .Mem_Rd(Mem_Rd), .Mem_Wr(Mem_Wr),
    .ALU_Cmd(ALU_Cmd), .ALU_En(ALU_En), .ACC_Out_En(ACC_Out_En),
    .Imm_Out_En(Imm_Out_En), .Halted(Halted), .Debug_IR(Debug_IR)
  );
  always @(negedge clk)
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      assert ((obs & e.m) === (e.v & e.m))
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs & e.m, e.v & e.m);
      end
    end
  task automatic push(input string tag);
    logic [3:0] op, cmd;
    logic ex, rd, alu, imm, sta;
    op = m_ir[11:8];
    ex = m_st == 2'd2 && !Reset;
    rd = ex && (op inside {4'd0, 4'd1, 4'd6, 4'd7, 4'd8});
    alu = ex && op <= 4'd9;
    imm = ex && op == 4'd9;
    sta = ex && op == 4'd10;
    cmd = op == 4'd9 ? 4'd8 : op <= 4'd8 ? op : 4'd0;
    q.push_back('{tag, {m_st == 2'd3 && !Reset, rd, sta, alu, sta, imm, cmd, m_ir[7:0],
                        m_ir[7:0], m_pc, m_ir},
                  {6'h3f, {4{alu}}, 8'hff, {8{imm}}, 8'hff, 12'hfff}});
  endtask
  task automatic step(input string tag);
    logic [3:0] op;
    push(tag);
    @(posedge clk);
    op = m_ir[11:8];
    if (Reset) begin
      m_st = 2'd0; m_pc = 8'h00; m_ir = 12'h000;
    end else if (m_st == 2'd0) begin
      m_ir = prog[m_pc]; m_pc = m_pc + 8'd1; m_st = 2'd1;
    end else if (m_st == 2'd1) m_st = 2'd2;
    else if (m_st == 2'd2) begin
      if (op == 4'hB || (op == 4'hC && C) || (op == 4'hD && !C)) m_pc = m_ir[7:0];
      m_st = op == 4'hF ? 2'd3 : 2'd0;
    end
    #1;
  endtask
  task automatic run(input logic c, input string tag);
    C = c;
    repeat (3) step(tag);
  endtask
  task automatic chk(input string tag, input logic [11:0] o, input logic [11:0] x);
    n_chk++;
    assert (o === x)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, x);
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) prog[i] = 12'hE00;
    @(posedge clk);
    #1;
    m_st = 2'd0; m_pc = 8'h00; m_ir = 12'h000;
    step("reset");
    chk("reset_pc", {4'h0, Prog_Addr}, 12'h000);
    chk("reset_strobes", {6'b0, Mem_Rd, Mem_Wr, ALU_En, ACC_Out_En, Imm_Out_En, Halted}, 12'h000);
    Reset = 1'b0;
    prog[0] = 12'h905; prog[1] = 12'hA10; prog[2] = 12'h020;
    step("ldi_f"); step("ldi_d");
    chk("ldi_exec", {6'b0, Imm_Out_En, ALU_En, ALU_Cmd}, 12'h038);
    chk("ldi_bus", {4'h0, ACC_bus}, 12'h005);
    step("ldi_e"); step("sta_f"); step("sta_d");
    chk("sta_exec", {2'b0, ACC_Out_En, Mem_Wr, Mem_Addr}, 12'h310);
    chk("sta_no_alu", {11'b0, ALU_En}, 12'h000);
    step("sta_e"); step("add_f"); step("add_d");
    chk("add_exec", {Mem_Rd, ALU_En, Imm_Out_En, ACC_Out_En, Mem_Addr}, 12'hC20);
    chk("add_cmd", {8'h00, ALU_Cmd}, 12'h000);
    Reset = 1'b1;
    step("reset_mid_exec");
    Reset = 1'b0;
    chk("mid_reset_pc", {4'h0, Prog_Addr}, 12'h000);
    chk("mid_reset_ir", Debug_IR, 12'h000);
    chk("mid_reset_strobes", {9'b0, Mem_Rd, ALU_En, Imm_Out_En}, 12'h000);
    for (int i = 0; i < 256; i++) prog[i] = 12'hE00;
    prog[8'h00] = 12'hC40; prog[8'h40] = 12'hC50; prog[8'h41] = 12'hD60;
    prog[8'h60] = 12'hD70; prog[8'h61] = 12'h133; prog[8'h62] = 12'h200;
    prog[8'h63] = 12'hBFF;
    run(1'b1, "jc_taken");
    chk("jc_taken_pc", {4'h0, Prog_Addr}, 12'h040);
    run(1'b0, "jc_not");
    chk("jc_not_pc", {4'h0, Prog_Addr}, 12'h041);
    run(1'b0, "jnc_taken");
    chk("jnc_taken_pc", {4'h0, Prog_Addr}, 12'h060);
    run(1'b1, "jnc_not");
    chk("jnc_not_pc", {4'h0, Prog_Addr}, 12'h061);
    run(1'b0, "sub"); run(1'b0, "clr"); run(1'b0, "jmp");
    chk("jmp_pc", {4'h0, Prog_Addr}, 12'h0FF);
    step("nop_ff_f");
    chk("pc_wrap", {4'h0, Prog_Addr}, 12'h000);
    step("nop_ff_d"); step("nop_ff_e"); step("wrap_f");
    chk("fetch_after_wrap", Debug_IR, 12'hC40);
    Reset = 1'b1;
    step("reset2");
    Reset = 1'b0;
    for (int i = 0; i < 256; i++) prog[i] = 12'hE00;
    prog[0] = 12'h500; prog[1] = 12'h611; prog[2] = 12'h722; prog[3] = 12'hF00;
    run(1'b0, "dcr"); run(1'b1, "and"); run(1'b0, "or");
    step("hlt_f"); step("hlt_d");
    chk("hlt_exec_not_halted", {11'b0, Halted}, 12'h000);
    step("hlt_e");
    chk("halted", {11'b0, Halted}, 12'h001);
    for (int i = 0; i < 20; i++) begin
      prog[m_pc] = 12'($urandom);
      C = 1'($urandom);
      step("halt_frozen");
    end
    chk("halt_pc", {4'h0, Prog_Addr}, 12'h004);
    chk("halt_ir", Debug_IR, 12'hF00);
    Reset = 1'b1;
    step("reset3");
    Reset = 1'b0;
    chk("restart_pc", {4'h0, Prog_Addr}, 12'h000);
    chk("restart_halted", {11'b0, Halted}, 12'h000);
    step("restart_f");
    chk("restart_ir", Debug_IR, 12'h500);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
